mc_ctrl: RTL and testbench

Multi-cycle main control unit for the MIPS datapath. Sequences each instruction through fetch/decode/execute/memory/writeback states. Drives the next-PC selector (`NPCOp`) and the PC write enable that the next-PC stage feeds into the PC register. Also generates IR, register-file, data-memory, ALU, extender and mux controls from the registered instruction's `Op`/`Funct` and the ALU `Zero` flag.

---
 rtl/mc_ctrl.sv | 140 ++++++++++++++
 tb/tb_mc_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// and drives PC, IR, register file, data memory, ALU, extender and mux controls.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic [1:0] NPCOp,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] ALUOp,
    output logic [1:0] EXTOp,
    output logic       BSel,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DCD    = 4'd1,
        MA     = 4'd2,
        MR     = 4'd3,
        MW     = 4'd4,
        WBM    = 4'd5,
        EXE    = 4'd6,
        WBA    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    state_t state, state_nxt;
    logic   pc_wr, ir_wr, rf_wr, dm_wr, ill;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_r    = (Op == 6'b000000);
    assign is_addu = is_r && (Funct == 6'b100001);
    assign is_subu = is_r && (Funct == 6'b100011);
    assign is_jr   = is_r && (Funct == 6'b001000);
    assign is_ori  = (Op == 6'b001101);
    assign is_lui  = (Op == 6'b001111);
    assign is_lw   = (Op == 6'b100011);
    assign is_sw   = (Op == 6'b101011);
    assign is_beq  = (Op == 6'b000100);
    assign is_j    = (Op == 6'b000010);
    assign is_jal  = (Op == 6'b000011);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        rf_wr     = 1'b0;
        dm_wr     = 1'b0;
        ill       = 1'b0;
        NPCOp     = 2'b00;
        ALUOp     = 2'b00;
        EXTOp     = 2'b00;
        BSel      = 1'b0;
        GPRSel    = 2'b00;
        WDSel     = 2'b00;
        case (state)
            FETCH: begin
                pc_wr     = 1'b1;
                ir_wr     = 1'b1;
                state_nxt = DCD;
            end
            DCD: begin
                if (is_lw || is_sw)                         state_nxt = MA;
                else if (is_addu || is_subu || is_ori || is_lui) state_nxt = EXE;
                else if (is_beq)                            state_nxt = BRANCH;
                else if (is_j || is_jal || is_jr)           state_nxt = JUMP;
                else begin
                    state_nxt = FETCH;
                    ill       = 1'b1;
                end
            end
            MA, MR, MW: begin
                // Address computation is held through the memory access cycle.
                BSel  = 1'b1;
                EXTOp = 2'b01;
                if (state == MA)      state_nxt = is_lw ? MR : (is_sw ? MW : FETCH);
                else if (state == MR) state_nxt = WBM;
                else                  dm_wr     = 1'b1;
            end
            WBM: begin
                rf_wr  = 1'b1;
                GPRSel = 2'b01;
                WDSel  = 2'b01;
            end
            EXE, WBA: begin
                if (is_subu) ALUOp = 2'b01;
                if (is_ori || is_lui) begin
                    ALUOp = 2'b10;
                    BSel  = 1'b1;
                    EXTOp = is_lui ? 2'b10 : 2'b00;
                end
                if (state == EXE) state_nxt = WBA;
                else begin
                    rf_wr  = 1'b1;
                    GPRSel = is_r ? 2'b00 : 2'b01;
                end
            end
            BRANCH: begin
                ALUOp = 2'b01;
                NPCOp = 2'b01;
                pc_wr = Zero;
            end
            JUMP: begin
                pc_wr = 1'b1;
                NPCOp = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    rf_wr  = 1'b1;
                    GPRSel = 2'b10;
                    WDSel  = 2'b10;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Write enables are gated by rst so an aborted instruction commits nothing.
    assign PCWr    = pc_wr & ~rst;
    assign IRWr    = ir_wr & ~rst;
    assign RFWr    = rf_wr & ~rst;
    assign DMWr    = dm_wr & ~rst;
    assign Illegal = ill & ~rst;
    assign State   = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: stimulus pushes per-cycle expected
// control records, a negedge monitor pops and compares them.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = '0, Funct = '0;
    logic       Zero = 1'b0;
    logic       PCWr, IRWr, RFWr, DMWr, BSel, Illegal;
    logic [1:0] NPCOp, ALUOp, EXTOp, GPRSel, WDSel;
    logic [3:0] State;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .RFWr(RFWr), .DMWr(DMWr),
        .ALUOp(ALUOp), .EXTOp(EXTOp), .BSel(BSel), .GPRSel(GPRSel),
        .WDSel(WDSel), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwr, irwr;
        logic [1:0] npc;
        logic       rfwr, dmwr;
        logic [1:0] alu, ext;
        logic       bsel;
        logic [1:0] gpr, wd;
        logic       ill;
    } rec_t;

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW,
                      K_BEQ, K_J, K_JAL, K_ILL} kind_t;

    rec_t q[$];
    int   checks = 0, failures = 0;
    bit   done = 0;

    function automatic rec_t actual();
        rec_t r;
        r = '{st: State, pcwr: PCWr, irwr: IRWr, npc: NPCOp, rfwr: RFWr,
              dmwr: DMWr, alu: ALUOp, ext: EXTOp, bsel: BSel, gpr: GPRSel,
              wd: WDSel, ill: Illegal};
        return r;
    endfunction

    function automatic int cpi(kind_t k);
        case (k)
            K_LW:                          return 5;
            K_SW, K_ADDU, K_SUBU,
            K_ORI, K_LUI:                  return 4;
            K_ILL:                         return 2;
            default:                       return 3;
        endcase
    endfunction

    // Expected controls for cycle 'step' of instruction 'k', built from the
    // instruction's documented behaviour rather than a state machine.
    function automatic rec_t model(kind_t k, int step, logic z);
        rec_t e;
        e = '0;
        if (step == 0) begin
            e.pcwr = 1; e.irwr = 1;
        end else if (step == 1) begin
            e.st  = 4'd1;
            e.ill = (k == K_ILL);
        end else begin
            case (k)
                K_LW, K_SW: begin
                    e.bsel = 1; e.ext = 2'b01;
                    if (step == 2)      e.st = 4'd2;
                    else if (k == K_SW) begin e.st = 4'd4; e.dmwr = 1; end
                    else if (step == 3) e.st = 4'd3;
                    else begin
                        e = '0; e.st = 4'd5; e.rfwr = 1; e.gpr = 2'b01; e.wd = 2'b01;
                    end
                end
                K_ADDU, K_SUBU, K_ORI, K_LUI: begin
                    e.st = (step == 2) ? 4'd6 : 4'd7;
                    if (k == K_SUBU) e.alu = 2'b01;
                    if (k == K_ORI || k == K_LUI) begin
                        e.alu = 2'b10; e.bsel = 1; e.ext = (k == K_LUI) ? 2'b10 : 2'b00;
                    end
                    if (step == 3) begin
                        e.rfwr = 1;
                        e.gpr  = (k == K_ORI || k == K_LUI) ? 2'b01 : 2'b00;
                    end
                end
                K_BEQ: begin
                    e.st = 4'd8; e.alu = 2'b01; e.npc = 2'b01; e.pcwr = z;
                end
                default: begin
                    e.st = 4'd9; e.pcwr = 1;
                    e.npc = (k == K_JR) ? 2'b11 : 2'b10;
                    if (k == K_JAL) begin e.rfwr = 1; e.gpr = 2'b10; e.wd = 2'b10; end
                end
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h (state %0d) required=%h (state %0d)",
                     name, $time, act, act.st, exp, exp.st);
        end
    endtask

    always @(negedge clk) begin
        if (rst) check("reset_state", actual(), '0 | (actual() & rec_t'(
                   {4'h0, 2'b00, 2'b11, 2'b00, 4'hF, 1'b1, 4'hF, 1'b0})));
        else if (q.size() > 0) check("cycle", actual(), q.pop_front());
        else if (!done) check("queue_underrun", actual(), '1);
    end

    task automatic pick(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] bad_ops [5];
        bad_ops = '{6'b111111, 6'b000001, 6'b001000, 6'b100000, 6'b000000};
        fn = 6'($urandom);
        case (k)
            K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
            K_JR:   begin op = 6'b000000; fn = 6'b001000; end
            K_ORI:  op = 6'b001101;
            K_LUI:  op = 6'b001111;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            default: begin
                op = bad_ops[$urandom_range(4, 0)];
                if (op == 6'b000000) fn = 6'b100000;
            end
        endcase
    endtask

    // Called at posedge+1 of the instruction's FETCH cycle; returns at the
    // same phase of the next FETCH cycle.
    task automatic run_instr(input kind_t k, input bit abort_mr);
        logic [5:0] op, fn;
        pick(k, op, fn);
        for (int s = 0; s < cpi(k); s++) begin
            if (s == 0) begin Op = op; Funct = fn; end
            Zero = 1'($urandom);
            if (abort_mr && s == 3) begin
                rst = 1;
                #1;
                check("async_abort", actual(), '0);
                repeat (2) begin @(posedge clk); #1; end
                rst = 0;
                return;
            end
            q.push_back(model(k, s, Zero));
            @(posedge clk); #1;
        end
    endtask

    kind_t directed [8] = '{K_LW, K_SW, K_ADDU, K_BEQ, K_BEQ, K_JAL, K_JR, K_ILL};

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        foreach (directed[i]) run_instr(directed[i], 0);
        for (int i = 0; i < 300; i++) run_instr(kind_t'($urandom_range(10, 0)), 0);
        run_instr(K_LW, 1);
        run_instr(K_LW, 0);
        run_instr(K_ADDU, 0);
        done = 1;
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d leftover required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
